// File: rtl/lcd_bus_ctrl.sv
// lcd_bus_ctrl: queues dr/wr draw requests and replays them as timed RS/E/DB writes to an 8-bit LCD
// Define LCD_INIT_SEQ_EN to run the panel power-up init sequence after reset.
module lcd_bus_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int T_SETUP    = 2,
    parameter int T_EHIGH    = 10,
    parameter int T_HOLD     = 10,
    parameter int T_EXEC     = 1440,
    parameter int T_CLEAR    = 32000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dr,
    input  logic [7:0] direc,
    input  logic       wr,
    input  logic [7:0] dbi,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [7:0] lcd_db,
    output logic       busy,
    output logic       done,
    output logic       ovf
);
    typedef enum logic [2:0] {IDLE, SETUP, EHI, HOLD, EXEC, PWR} state_t;
`ifdef LCD_INIT_SEQ_EN
    localparam int     T_PWR  = 800000;
    localparam state_t RST_ST = PWR;
`else
    localparam int     T_PWR  = 0;
    localparam state_t RST_ST = IDLE;
`endif
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int TM0  = T_CLEAR > T_EXEC ? T_CLEAR : T_EXEC;
    localparam int TMAX = T_PWR > TM0 ? T_PWR : TM0;
    localparam int CW   = $clog2(TMAX + 1);
    localparam logic [CW-1:0] RST_CNT = CW'(T_PWR > 0 ? T_PWR - 1 : 0);

    state_t        state, nxt;
    logic [CW-1:0] cnt, cnt_n;
    logic          dr_q, wr_q, pend_v;
    logic [7:0]    pend_d;
    logic [8:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wp, rp;
    logic          empty, full, dr_e, wr_e, push_v, pop, accept, load, last, is_clr;
    logic [8:0]    push_d, head;
    logic          init_pend, init_xfer;
    logic [7:0]    init_cmd;

    assign empty  = wp == rp;
    assign full   = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign dr_e   = dr & ~dr_q;
    assign wr_e   = wr & ~wr_q;
    // a data edge coinciding with a command edge waits one cycle in pend_d
    assign push_v = pend_v | dr_e | wr_e;
    assign push_d = pend_v ? {1'b1, pend_d} : dr_e ? {1'b0, direc} : {1'b1, dbi};
    assign head   = mem[rp[AW-1:0]];
    assign pop    = state == IDLE && !empty && !init_pend;
    assign load   = state == IDLE && (pop || init_pend);
    assign accept = push_v && (!full || pop);
    assign last   = cnt == '0;
    assign is_clr = {lcd_rs, lcd_db} == 9'h001;

`ifdef LCD_INIT_SEQ_EN
    logic [2:0] init_idx;
    assign init_pend = init_idx != 3'd5;
    assign init_cmd  = init_idx == 3'd2 ? 8'h0C : init_idx == 3'd3 ? 8'h01 :
                       init_idx == 3'd4 ? 8'h06 : 8'h30;
    always_ff @(posedge clk) begin
        if (rst) begin
            init_idx  <= '0;
            init_xfer <= 1'b0;
        end else if (state == IDLE) begin
            init_xfer <= init_pend;
            if (init_pend) init_idx <= init_idx + 3'd1;
        end
    end
`else
    assign init_pend = 1'b0;
    assign init_cmd  = 8'h00;
    assign init_xfer = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= RST_ST;
            cnt    <= RST_CNT;
            dr_q   <= dr;
            wr_q   <= wr;
            pend_v <= 1'b0;
            pend_d <= '0;
            wp     <= '0;
            rp     <= '0;
            ovf    <= 1'b0;
            busy   <= 1'b0;
            lcd_rs <= 1'b0;
            lcd_db <= '0;
        end else begin
            state  <= nxt;
            cnt    <= cnt_n;
            dr_q   <= dr;
            wr_q   <= wr;
            pend_v <= dr_e & wr_e;
            pend_d <= dbi;
            busy   <= state != IDLE || !empty || init_pend;
            ovf    <= ovf | (push_v & full & ~pop);
            if (accept) begin
                mem[wp[AW-1:0]] <= push_d;
                wp <= wp + (AW+1)'(1);
            end
            if (pop) rp <= rp + (AW+1)'(1);
            if (load) {lcd_rs, lcd_db} <= init_pend ? {1'b0, init_cmd} : head;
        end
    end

    always_comb begin
        nxt   = state;
        cnt_n = last ? '0 : cnt - CW'(1);
        case (state)
            IDLE:    if (load) begin nxt = SETUP; cnt_n = CW'(T_SETUP - 1); end
            SETUP:   if (last) begin nxt = EHI;   cnt_n = CW'(T_EHIGH - 1); end
            EHI:     if (last) begin nxt = HOLD;  cnt_n = CW'(T_HOLD - 1); end
            HOLD:    if (last) begin nxt = EXEC;  cnt_n = is_clr ? CW'(T_CLEAR - 1) : CW'(T_EXEC - 1); end
            default: if (last) nxt = IDLE;
        endcase
    end

    always_comb begin
        lcd_e  = state == EHI;
        lcd_rw = 1'b0;
        done   = state == EXEC && last && !init_xfer;
    end
endmodule
